vga_pic_bounce: RTL and testbench

- Pixel-source stage that drives the jpg_colour input of VGA_Ctrl from the jpg_x/jpg_y coordinates VGA_Ctrl issues.
- Draws a 640x480 RGB565 background of ten vertical colour bars, with a solid square overlaid on top.
- The square moves diagonally and bounces off the screen edges, advancing once every FRAME_DIV frames.
- Runs in the 25 MHz VGA_clk domain beside VGA_Ctrl.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_pic_bounce_bounce_pos_ctrl.sv | 56 +++++
 rtl/vga_pic_bounce.sv | 50 +++++
 tb/tb_vga_pic_bounce.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry defaults, RGB565 palette, direction encoding and colour-bar lookup.
package vga_pkg;
   localparam int H_VALID_DEF = 640;
   localparam int V_VALID_DEF = 480;
   localparam logic [15:0] WHITE   = 16'hFFFF;
   localparam logic [15:0] BLACK   = 16'h0000;
   localparam logic [15:0] RED     = 16'hF800;
   localparam logic [15:0] GREEN   = 16'h07E0;
   localparam logic [15:0] BLUE    = 16'h001F;
   localparam logic [15:0] YELLOW  = 16'hFFE0;
   localparam logic [15:0] CYAN    = 16'h07FF;
   localparam logic [15:0] MAGENTA = 16'hF81F;
   localparam logic [15:0] GREY    = 16'h8410;
   localparam logic [15:0] ORANGE  = 16'hFC00;
   localparam logic DIR_POS = 1'b0;
   localparam logic DIR_NEG = 1'b1;

   function automatic logic [15:0] bar_colour(input logic [3:0] idx);
      case (idx)
         4'd0: return WHITE;
         4'd1: return BLACK;
         4'd2: return RED;
         4'd3: return GREEN;
         4'd4: return BLUE;
         4'd5: return YELLOW;
         4'd6: return CYAN;
         4'd7: return MAGENTA;
         4'd8: return GREY;
         4'd9: return ORANGE;
         default: return BLACK;
      endcase
   endfunction
endpackage

// File: rtl/vga_pic_bounce_bounce_pos_ctrl.sv
// bounce_pos_ctrl: frame-end detection, frame divider and bouncing square position/direction state.
module bounce_pos_ctrl import vga_pkg::*; #(
   parameter int H_VALID   = H_VALID_DEF,
   parameter int V_VALID   = V_VALID_DEF,
   parameter int BOX_SIZE  = 64,
   parameter int STEP      = 2,
   parameter int FRAME_DIV = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] jpg_x,
   input  logic [9:0] jpg_y,
   output logic [9:0] box_x,
   output logic [9:0] box_y,
   output logic       bounce
);
   localparam int CW = FRAME_DIV > 1 ? $clog2(FRAME_DIV) : 1;
   logic match, match_d, fe, upd, dir_x, dir_y, flip_x, flip_y;
   logic [CW-1:0] cnt;
   logic [9:0] nx, ny;
   always_comb begin
      match  = jpg_x == 10'(H_VALID - 1) && jpg_y == 10'(V_VALID - 1);
      fe     = match && !match_d;
      // 11-bit sums so the right/bottom edge test cannot wrap
      flip_x = dir_x == DIR_POS ? 11'(box_x) + 11'(BOX_SIZE + STEP) > 11'(H_VALID) : box_x < 10'(STEP);
      flip_y = dir_y == DIR_POS ? 11'(box_y) + 11'(BOX_SIZE + STEP) > 11'(V_VALID) : box_y < 10'(STEP);
      nx = flip_x ? (dir_x == DIR_POS ? 10'(H_VALID - BOX_SIZE) : 10'd0)
                  : (dir_x == DIR_POS ? box_x + 10'(STEP) : box_x - 10'(STEP));
      ny = flip_y ? (dir_y == DIR_POS ? 10'(V_VALID - BOX_SIZE) : 10'd0)
                  : (dir_y == DIR_POS ? box_y + 10'(STEP) : box_y - 10'(STEP));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         match_d <= 1'b0;
         cnt     <= '0;
         upd     <= 1'b0;
         box_x   <= '0;
         box_y   <= '0;
         dir_x   <= DIR_POS;
         dir_y   <= DIR_POS;
         bounce  <= 1'b0;
      end else begin
         match_d <= match;
         upd     <= fe && cnt == CW'(FRAME_DIV - 1);
         bounce  <= upd && (flip_x || flip_y);
         if (fe)
            cnt <= cnt == CW'(FRAME_DIV - 1) ? '0 : cnt + 1'b1;
         if (upd) begin
            box_x <= nx;
            box_y <= ny;
            dir_x <= flip_x ? (dir_x == DIR_POS ? DIR_NEG : DIR_POS) : dir_x;
            dir_y <= flip_y ? (dir_y == DIR_POS ? DIR_NEG : DIR_POS) : dir_y;
         end
      end
   end
endmodule

// File: rtl/vga_pic_bounce.sv
// vga_pic_bounce: ten colour bars with a bouncing square overlay, registered RGB565 pixel output.
// Define VGA_BOUNCE_BORDER_EN to draw a 2 px black border inside the square.
module vga_pic_bounce import vga_pkg::*; #(
   parameter int          H_VALID    = H_VALID_DEF,
   parameter int          V_VALID    = V_VALID_DEF,
   parameter int          BOX_SIZE   = 64,
   parameter int          STEP       = 2,
   parameter int          FRAME_DIV  = 1,
   parameter logic [15:0] BOX_COLOUR = 16'hFFFF
) (
   input  logic        Clk_int,
   input  logic        Sys_Rst,
   input  logic [9:0]  jpg_x,
   input  logic [9:0]  jpg_y,
   output logic [15:0] jpg_colour,
   output logic [9:0]  box_x,
   output logic [9:0]  box_y,
   output logic        bounce
);
   logic [10:0] px, py, bx, by;
   logic hit;
   logic [15:0] colour;
`ifdef VGA_BOUNCE_BORDER_EN
   logic [10:0] dx, dy;
   logic edge_px;
`endif
   bounce_pos_ctrl #(
      .H_VALID(H_VALID), .V_VALID(V_VALID), .BOX_SIZE(BOX_SIZE), .STEP(STEP), .FRAME_DIV(FRAME_DIV)
   ) u_pos (
      .clk(Clk_int), .rst(Sys_Rst), .jpg_x(jpg_x), .jpg_y(jpg_y),
      .box_x(box_x), .box_y(box_y), .bounce(bounce)
   );
   always_comb begin
      px  = 11'(jpg_x);
      py  = 11'(jpg_y);
      bx  = 11'(box_x);
      by  = 11'(box_y);
      hit = px >= bx && px < bx + 11'(BOX_SIZE) && py >= by && py < by + 11'(BOX_SIZE);
`ifdef VGA_BOUNCE_BORDER_EN
      dx      = px - bx;
      dy      = py - by;
      edge_px = dx < 11'd2 || dx >= 11'(BOX_SIZE - 2) || dy < 11'd2 || dy >= 11'(BOX_SIZE - 2);
      colour  = hit ? (edge_px ? BLACK : BOX_COLOUR) : bar_colour(jpg_x[9:6]);
`else
      colour  = hit ? BOX_COLOUR : bar_colour(jpg_x[9:6]);
`endif
   end
   always_ff @(posedge Clk_int)
      jpg_colour <= Sys_Rst ? 16'h0000 : colour;
endmodule

// File: tb/tb_vga_pic_bounce.sv
// tb_vga_pic_bounce: randomized checks of two instances (FRAME_DIV 1 and 3) against a behavioural model.
module tb_vga_pic_bounce;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [9:0] jx = '0, jy = '0;
   logic [15:0] col [2];
   logic [9:0] obx [2], oby [2];
   logic obn [2];
   int checks = 0, failures = 0;
   int mx [2], my [2], mcnt [2];
   bit mdx [2], mdy [2], mflip [2];
   int div [2] = '{1, 3};
   logic [15:0] bars [10] = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0, 16'h001F,
                              16'hFFE0, 16'h07FF, 16'hF81F, 16'h8410, 16'hFC00};

   always #20 clk = ~clk;

   vga_pic_bounce dut (
      .Clk_int(clk), .Sys_Rst(rst), .jpg_x(jx), .jpg_y(jy),
      .jpg_colour(col[0]), .box_x(obx[0]), .box_y(oby[0]), .bounce(obn[0])
   );
   vga_pic_bounce #(.FRAME_DIV(3)) dut3 (
      .Clk_int(clk), .Sys_Rst(rst), .jpg_x(jx), .jpg_y(jy),
      .jpg_colour(col[1]), .box_x(obx[1]), .box_y(oby[1]), .bounce(obn[1])
   );

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mx[i] = 0; my[i] = 0; mcnt[i] = 0; mdx[i] = 0; mdy[i] = 0; mflip[i] = 0;
      end
   endtask

   function automatic void move(inout int p, inout bit d, input int lim, output bit f);
      f = 0;
      if (!d) begin
         if (p + 66 > lim) begin p = lim - 64; d = 1; f = 1; end
         else p = p + 2;
      end else begin
         if (p < 2) begin p = 0; d = 0; f = 1; end
         else p = p - 2;
      end
   endfunction

   task automatic model_fe();
      for (int i = 0; i < 2; i++) begin
         int p, q;
         bit d, e, fx, fy;
         mflip[i] = 0;
         if (mcnt[i] == div[i] - 1) begin
            mcnt[i] = 0;
            p = mx[i]; d = mdx[i]; move(p, d, 640, fx); mx[i] = p; mdx[i] = d;
            q = my[i]; e = mdy[i]; move(q, e, 480, fy); my[i] = q; mdy[i] = e;
            mflip[i] = fx | fy;
         end else mcnt[i]++;
      end
   endtask

   function automatic logic [15:0] exp_colour(input int i, input int x, input int y);
      int rx, ry;
      rx = x - mx[i];
      ry = y - my[i];
      if (rx >= 0 && rx < 64 && ry >= 0 && ry < 64) begin
`ifdef VGA_BOUNCE_BORDER_EN
         if (rx < 2 || rx > 61 || ry < 2 || ry > 61) return 16'h0000;
`endif
         return 16'hFFFF;
      end
      return (x / 64 < 10) ? bars[x / 64] : 16'h0000;
   endfunction

   task automatic check_pix(input int x, input int y);
      logic [15:0] e;
      @(negedge clk); jx = 10'(x); jy = 10'(y);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         e = exp_colour(i, x, y);
         if (col[i] !== e) begin
            failures++;
            $display("FAIL colour dut%0d (%0d,%0d): got %h want %h", i, x, y, col[i], e);
         end
         checks++;
      end
   endtask

   task automatic rand_pix();
      int x, y;
      if ($urandom_range(0, 1) == 1) begin
         x = mx[0] + int'($urandom_range(0, 66)) - 1;
         y = my[0] + int'($urandom_range(0, 66)) - 1;
         if (x < 0) x = 0;
         if (y < 0) y = 0;
      end else begin
         x = int'($urandom_range(0, 1023));
         y = int'($urandom_range(0, 524));
      end
      if (x == 639 && y == 479) y = 0;
      check_pix(x, y);
   endtask

   task automatic check_state(input string tag, input bit want_bounce);
      for (int i = 0; i < 2; i++) begin
         bit wb;
         wb = want_bounce & mflip[i];
         if (obx[i] !== 10'(mx[i]) || oby[i] !== 10'(my[i])) begin
            failures++;
            $display("FAIL %s box dut%0d: got (%0d,%0d) want (%0d,%0d)", tag, i, obx[i], oby[i], mx[i], my[i]);
         end
         checks++;
         if (obn[i] !== wb) begin
            failures++;
            $display("FAIL %s bounce dut%0d: got %b want %b", tag, i, obn[i], wb);
         end
         checks++;
      end
   endtask

   task automatic do_frame(input int hold);
      @(negedge clk); jx = 10'd639; jy = 10'd479;
      model_fe();
      for (int k = 1; k <= 2 || k <= hold; k++) begin
         @(negedge clk);
         if (k == hold) begin
            jx = 10'($urandom_range(0, 638));
            jy = 10'($urandom_range(0, 478));
         end
         if (k == 2) check_state("frame", 1'b1);
      end
      @(negedge clk);
      check_state("after_frame", 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1; jx = '0; jy = '0;
      model_reset();
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         if (col[i] !== 16'h0000) begin
            failures++;
            $display("FAIL reset_colour dut%0d: got %h want 0000", i, col[i]);
         end
         checks++;
      end
      check_state("reset", 1'b0);
      rst = 1'b0;
      check_pix(0, 0);
   endtask

   task automatic test_bars();
      check_pix(100, 300);
      check_pix(200, 300);
      check_pix(639, 300);
      check_pix(700, 100);
      check_pix(63, 63);
      check_pix(64, 63);
      check_pix(63, 64);
      for (int n = 0; n < 40; n++) rand_pix();
   endtask

   task automatic test_three_frames();
      do_frame(1);
      do_frame(5);
      do_frame(1);
      if (obx[0] !== 10'd6 || oby[0] !== 10'd6) begin
         failures++;
         $display("FAIL three_frames: got (%0d,%0d) want (6,6)", obx[0], oby[0]);
      end
      checks++;
      if (obx[1] !== 10'd2 || oby[1] !== 10'd2) begin
         failures++;
         $display("FAIL three_frames_div3: got (%0d,%0d) want (2,2)", obx[1], oby[1]);
      end
      checks++;
      for (int n = 0; n < 10; n++) rand_pix();
   endtask

   task automatic test_bounce();
      do_reset();
      for (int f = 1; f <= 600; f++) begin
         do_frame(1 + int'($urandom_range(0, 3)));
         if (f == 288 || f == 289 || f == 290) begin
            if (obx[0] !== (f == 290 ? 10'd574 : 10'd576)) begin
               failures++;
               $display("FAIL bounce_right frame %0d: got %0d", f, obx[0]);
            end
            checks++;
         end
         if (f % 8 == 0) rand_pix();
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk); jx = 10'd639; jy = 10'd479;
      @(negedge clk); rst = 1'b1; jx = 10'd320; jy = 10'd240;
      @(negedge clk);
      model_reset();
      for (int i = 0; i < 2; i++) begin
         if (col[i] !== 16'h0000 || obx[i] !== 10'd0 || oby[i] !== 10'd0) begin
            failures++;
            $display("FAIL mid_reset dut%0d: got col %h box (%0d,%0d) want 0000 (0,0)", i, col[i], obx[i], oby[i]);
         end
         checks++;
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_state("discard", 1'b0);
      check_pix(320, 240);
   endtask

   task automatic test_border();
      check_pix(1, 10);
      check_pix(10, 10);
      check_pix(63, 63);
      check_pix(62, 30);
      check_pix(61, 30);
   endtask

   initial begin
      test_reset();
      test_bars();
      test_three_frames();
      test_bounce();
      test_mid_reset();
      test_border();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
